// File: rtl/state_machine.sv
// Three-channel alarm controller: debounces sensors, sounds the highest-priority qualified buzzer.
// Latency: buzzer rises DEBOUNCE+1 edges after sensor is first sampled high; falls 2 edges after release.
// Backpressure: none; sensors are sampled every cycle and buzzers are pure Moore decodes.
module state_machine #(
    parameter int DEBOUNCE  = 2,
    parameter int BEEP_HALF = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sensor1,
    input  logic sensor2,
    input  logic sensor3,
    output logic buzzer1,
    output logic buzzer2,
    output logic buzzer3
);

    // Counter widths sized so the saturation value and the beep period both fit.
    localparam int CW = (DEBOUNCE + 1 > 2) ? $clog2(DEBOUNCE + 1) : 1;
    localparam int PW = (2 * BEEP_HALF > 2) ? $clog2(2 * BEEP_HALF) : 1;

    localparam logic [CW-1:0] DB_MAX  = CW'(DEBOUNCE);
    localparam logic [PW-1:0] PH_LAST = PW'(2 * BEEP_HALF - 1);
    localparam logic [PW-1:0] PH_HALF = PW'(BEEP_HALF);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ALARM1 = 2'd1;
    localparam logic [1:0] ALARM2 = 2'd2;
    localparam logic [1:0] ALARM3 = 2'd3;

    logic [2:0]    sensor_v;
    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];
    logic [2:0]    qual;
    logic [1:0]    state;
    logic [1:0]    state_d;
    logic [PW-1:0] phase;
    logic [PW-1:0] phase_d;

    // Index 0 is the lowest-priority channel so bit position matches channel number minus one.
    assign sensor_v = {sensor3, sensor2, sensor1};

    // Next debounce count: saturate while high, clear on any low sample.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (sensor_v[i]) begin
                cnt_d[i] = (cnt_q[i] == DB_MAX) ? cnt_q[i] : cnt_q[i] + 1'b1;
            end
        end
    end

    // Debounce counters and qualified flags; a flag tracks whether the new count hit saturation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
            qual <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
                qual[i]  <= (cnt_d[i] == DB_MAX);
            end
        end
    end

    // Priority select from the registered flags; preemption works in both directions every cycle.
    always_comb begin
        state_d = IDLE;
        if (qual[2]) begin
            state_d = ALARM3;
        end else if (qual[1]) begin
            state_d = ALARM2;
        end else if (qual[0]) begin
            state_d = ALARM1;
        end
    end

    // Beep phase restarts on every state change so a new alarm always opens with the high half.
    always_comb begin
        phase_d = '0;
        if (state_d != IDLE && state_d == state) begin
            phase_d = (phase == PH_LAST) ? '0 : phase + 1'b1;
        end
    end

    // State and phase registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            phase <= '0;
        end else begin
            state <= state_d;
            phase <= phase_d;
        end
    end

    // Moore decode: only the channel owning the state can drive, so at most one buzzer is high.
    assign buzzer1 = (state == ALARM1) && (phase < PH_HALF);
    assign buzzer2 = (state == ALARM2) && (phase < PH_HALF);
    assign buzzer3 = (state == ALARM3) && (phase < PH_HALF);

endmodule

// File: tb/tb_state_machine.sv
// Directed bench for state_machine with DEBOUNCE=2, BEEP_HALF=2.
// Inputs change 1 time unit after each rising edge; outputs are checked at the same point.
// Expected buzzer vectors are hand-derived from the debounce/priority/beep timing.
module tb_state_machine;

    logic clk = 1'b0;
    logic reset;
    logic sensor1;
    logic sensor2;
    logic sensor3;
    logic buzzer1;
    logic buzzer2;
    logic buzzer3;

    int total = 0;
    int bad   = 0;

    state_machine #(
        .DEBOUNCE  (2),
        .BEEP_HALF (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sensor1 (sensor1),
        .sensor2 (sensor2),
        .sensor3 (sensor3),
        .buzzer1 (buzzer1),
        .buzzer2 (buzzer2),
        .buzzer3 (buzzer3)
    );

    always #5 clk = ~clk;

    // Compare {buzzer3,buzzer2,buzzer1} against the expected vector.
    task automatic chk(input string tag, input logic [2:0] exp);
        logic [2:0] obs;
        obs = {buzzer3, buzzer2, buzzer1};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: buzzers=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Apply sensors {s3,s2,s1}, advance one rising edge, then check.
    task automatic cyc(input string tag, input logic [2:0] s, input logic [2:0] exp);
        {sensor3, sensor2, sensor1} = s;
        @(posedge clk);
        #1;
        chk(tag, exp);
    endtask

    initial begin
        logic [11:0] pat;
        logic [2:0]  one;
        logic [2:0]  s;
        logic [2:0]  e;

        // Reset held for two edges with sensors idle.
        reset = 1'b1;
        {sensor3, sensor2, sensor1} = 3'b000;
        #1;
        chk("reset_t0", 3'b000);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("reset_hold", 3'b000);
        end
        reset = 1'b0;
        cyc("post_reset_1", 3'b000, 3'b000);
        cyc("post_reset_2", 3'b000, 3'b000);

        // Each channel alone: 10 edges high, then low. Pattern per edge 1..12:
        // 0,0,1,1,0,0,1,1,0,0,1,0 (edge 11 still in alarm at phase 0, edge 12 back to idle).
        pat = 12'b0100_1100_1100;
        one = 3'b001;
        for (int ch = 0; ch < 3; ch++) begin
            for (int i = 0; i < 12; i++) begin
                s = (i < 10) ? (one << ch) : 3'b000;
                e = pat[i] ? (one << ch) : 3'b000;
                cyc($sformatf("single_ch%0d_e%0d", ch + 1, i + 1), s, e);
            end
            cyc($sformatf("single_ch%0d_idle", ch + 1), 3'b000, 3'b000);
        end

        // sensor2 and sensor3 together: only buzzer3 beeps, entering alarm at edge 3.
        for (int i = 0; i < 40; i++) begin
            e = (i >= 2 && ((i - 2) % 4) < 2) ? 3'b100 : 3'b000;
            cyc($sformatf("dual_e%0d", i + 1), 3'b110, e);
        end
        // Drop sensor3: q3 clears at edge 41, ALARM2 at edge 42 with phase restarted.
        cyc("drop3_e41", 3'b010, 3'b000);
        cyc("drop3_e42", 3'b010, 3'b010);
        cyc("drop3_e43", 3'b010, 3'b010);
        cyc("drop3_e44", 3'b010, 3'b000);
        cyc("drop3_e45", 3'b010, 3'b000);
        cyc("drop3_e46", 3'b010, 3'b010);
        cyc("drop2_e47", 3'b000, 3'b010);
        cyc("drop2_e48", 3'b000, 3'b000);

        // One-edge glitch on sensor1 never qualifies.
        cyc("glitch_e1", 3'b001, 3'b000);
        for (int i = 0; i < 4; i++) begin
            cyc($sformatf("glitch_after_%0d", i + 1), 3'b000, 3'b000);
        end

        // sensor1 held, sensor3 raised at edge 3: buzzer1 drops at edge 5 as buzzer3 rises.
        cyc("pre_e1", 3'b001, 3'b000);
        cyc("pre_e2", 3'b001, 3'b000);
        cyc("pre_e3", 3'b101, 3'b001);
        cyc("pre_e4", 3'b101, 3'b001);
        cyc("pre_e5", 3'b101, 3'b100);
        cyc("pre_e6", 3'b101, 3'b100);
        cyc("pre_e7", 3'b101, 3'b000);
        cyc("pre_e8", 3'b101, 3'b000);
        cyc("pre_e9", 3'b101, 3'b100);
        // sensor3 released: channel 1 takes over one edge later with no re-debounce.
        cyc("pre_e10", 3'b001, 3'b100);
        cyc("pre_e11", 3'b001, 3'b001);
        cyc("pre_e12", 3'b001, 3'b001);
        cyc("pre_e13", 3'b001, 3'b000);
        cyc("pre_e14", 3'b000, 3'b000);
        cyc("pre_e15", 3'b000, 3'b000);

        // Reset between edges while buzzer2 is sounding.
        cyc("rst_e1", 3'b010, 3'b000);
        cyc("rst_e2", 3'b010, 3'b000);
        cyc("rst_e3", 3'b010, 3'b010);
        cyc("rst_e4", 3'b010, 3'b010);
        #3;
        reset = 1'b1;
        #1;
        chk("rst_async_drop", 3'b000);
        @(posedge clk);
        #1;
        chk("rst_async_hold", 3'b000);
        reset = 1'b0;
        // sensor2 still high: requalifies from zero, buzzer2 back after the third edge.
        cyc("rst_rel_e1", 3'b010, 3'b000);
        cyc("rst_rel_e2", 3'b010, 3'b000);
        cyc("rst_rel_e3", 3'b010, 3'b010);
        cyc("rst_rel_e4", 3'b010, 3'b010);
        cyc("rst_rel_e5", 3'b010, 3'b000);
        cyc("rst_rel_e6", 3'b000, 3'b000);
        cyc("rst_rel_e7", 3'b000, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
